program_loader: RTL and testbench

- Boot-time controller that fills the instruction ROM of the single-cycle MIPS core from an 8-bit byte stream (UART/debug bridge) and keeps the CPU held while loading.
- Packs little-endian bytes into 32-bit words and issues one write per word. Write addresses are byte addresses in program space, starting at BASE_ADDRESS (0x400000).
- The memory strips the base and word-aligns the address.

---
 rtl/program_loader.sv | 149 ++++++++++++++
 tb/tb_program_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time loader: packs a little-endian byte stream into 32-bit words and writes them to program memory.
// Optional trailing checksum byte is enabled with the PROGRAM_LOADER_CHECKSUM_EN macro.
module program_loader #(
  parameter int          MEMORY_DEPTH = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] word_count_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  cpu_hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_CHECK, S_DONE, S_ERROR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_ERROR} state_t;
`endif

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        last_idx;
  logic [IDX_W-1:0]        word_index;
  logic [1:0]              byte_cnt;
  logic [23:0]             word_buf;
  logic [DATA_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_data_q;
  logic                    start_ok;
  logic                    load_go;
  logic                    byte_fire;
  logic                    data_fire;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]              sum;
`endif

  assign start_ok  = (word_count_i != '0) && (word_count_i <= DATA_WIDTH'(MEMORY_DEPTH));
  assign byte_fire = byte_valid_i && byte_ready_o;
  assign data_fire = byte_fire && (state == S_LOAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_idx   <= '0;
      word_index <= '0;
      byte_cnt   <= '0;
      word_buf   <= '0;
      mem_addr_q <= BASE_ADDRESS;
      mem_data_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      if (load_go) begin
        last_idx   <= IDX_W'(word_count_i - 1'b1);
        word_index <= '0;
        byte_cnt   <= '0;
        word_buf   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum        <= '0;
`endif
      end
      if (data_fire) begin
        byte_cnt <= byte_cnt + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum      <= sum + byte_i;
`endif
        if (byte_cnt == 2'd3) begin
          mem_data_q <= {byte_i, word_buf};
          mem_addr_q <= BASE_ADDRESS + (DATA_WIDTH'(word_index) << 2);
        end else begin
          word_buf[{byte_cnt, 3'b000} +: 8] <= byte_i;
        end
      end
      // Saturate at the last index so the address never leaves the loaded range.
      if (state == S_WRITE && word_index != last_idx)
        word_index <= word_index + 1'b1;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch can be inferred.
    state_nxt    = state;
    load_go      = 1'b0;
    byte_ready_o = 1'b0;
    busy_o       = 1'b0;
    cpu_hold_o   = 1'b0;
    done_o       = 1'b0;
    error_o      = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        done_o     = (state == S_DONE);
        error_o    = (state == S_ERROR);
        cpu_hold_o = (state == S_ERROR);
        if (start_i) begin
          load_go   = start_ok;
          state_nxt = start_ok ? S_LOAD : S_ERROR;
        end
      end
      S_LOAD: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        cpu_hold_o   = 1'b1;
        if (byte_valid_i && byte_cnt == 2'd3)
          state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy_o     = 1'b1;
        cpu_hold_o = 1'b1;
        if (word_index != last_idx)
          state_nxt = S_LOAD;
        else
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_nxt = S_CHECK;
`else
          state_nxt = S_DONE;
`endif
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        cpu_hold_o   = 1'b1;
        if (byte_valid_i)
          state_nxt = (8'(sum + byte_i) == 8'h00) ? S_DONE : S_ERROR;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobe is masked while reset is high so an interrupted WRITE never reaches memory.
  assign mem_we_o   = (state == S_WRITE) && !reset;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: packing, addressing, count errors, full depth,
// reset during WRITE, and the trailing checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [31:0] word_count_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        cpu_hold_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_viol = 0;
  logic [7:0]  tb_sum;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  program_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .word_count_i (word_count_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .cpu_hold_o   (cpu_hold_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  // Write capture, sampled mid-low-phase after inputs driven at the falling edge have settled.
  always begin
    @(negedge clk);
    #2;
    if (mem_we_o) begin
      wr_addr.push_back(mem_addr_o);
      wr_data.push_back(mem_data_o);
      if (byte_ready_o) ready_viol++;
    end
  end

  // Called at a falling edge; returns at the falling edge right after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      byte_valid_i = 1'b0;
      @(negedge clk);
    end
    byte_i       = b;
    byte_valid_i = 1'b1;
    n = 0;
    while (!byte_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      $display("FAIL send_byte: byte_ready_o stuck at %0b, required 1", byte_ready_o);
      $fatal(1, "loader never became ready");
    end
    @(negedge clk);
    tb_sum = tb_sum + b;
  endtask

  task automatic do_start(input logic [31:0] cnt);
    byte_valid_i = 1'b0;
    start_i      = 1'b1;
    word_count_i = cnt;
    tb_sum       = 8'h00;
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic finish_check();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'(~tb_sum + 8'h01), 0);
    byte_valid_i = 1'b0;
`endif
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    byte_valid_i = 1'b0;
    while (!(done_o || error_o) && n < 500) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 500) begin
      n_fail++;
      $display("FAIL %s timeout: done_o=%0b error_o=%0b, required one of them 1", name, done_o, error_o);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_i = 1'b0; word_count_i = '0; byte_i = '0; byte_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({mem_we_o, byte_ready_o, cpu_hold_o, busy_o, done_o, error_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: we/ready/hold/busy/done/err=%b, required 000000",
               {mem_we_o, byte_ready_o, cpu_hold_o, busy_o, done_o, error_o});
    end
    n_checks++;
    if (mem_addr_o !== BASE || mem_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mem: addr=%h data=%h, required %h 00000000", mem_addr_o, mem_data_o, BASE);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[8] = '{8'h20, 8'h00, 8'h08, 8'h20, 8'hFF, 8'hFF, 8'h09, 8'h21};
    do_start(32'd2);
    n_checks++;
    if (busy_o !== 1'b1 || cpu_hold_o !== 1'b1 || byte_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_load_state: busy=%0b hold=%0b ready=%0b, required 1 1 1", busy_o, cpu_hold_o, byte_ready_o);
    end
    for (int i = 0; i < 8; i++) send_byte(b[i], 0);
    byte_valid_i = 1'b0;
    @(negedge clk);
    finish_check();
    wait_end("b2b");
    n_checks++;
    if (wr_addr.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: writes=%0d, required 2", wr_addr.size());
    end else begin
      n_checks++;
      if (wr_addr[0] !== 32'h0040_0000 || wr_data[0] !== 32'h2008_0020) begin
        n_fail++;
        $display("FAIL b2b_word0: %h@%h, required 20080020@00400000", wr_data[0], wr_addr[0]);
      end
      n_checks++;
      if (wr_addr[1] !== 32'h0040_0004 || wr_data[1] !== 32'h2109_FFFF) begin
        n_fail++;
        $display("FAIL b2b_word1: %h@%h, required 2109ffff@00400004", wr_data[1], wr_addr[1]);
      end
    end
    n_checks++;
    if (done_o !== 1'b1 || cpu_hold_o !== 1'b0 || busy_o !== 1'b0 || error_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done: done=%0b hold=%0b busy=%0b err=%0b, required 1 0 0 0", done_o, cpu_hold_o, busy_o, error_o);
    end
    n_checks++;
    if (mem_addr_o !== 32'h0040_0004 || mem_data_o !== 32'h2109_FFFF) begin
      n_fail++;
      $display("FAIL b2b_hold_value: %h@%h, required 2109ffff@00400004", mem_data_o, mem_addr_o);
    end
  endtask

  task automatic test_toggle();
    logic [7:0] b[8] = '{8'h20, 8'h00, 8'h08, 8'h20, 8'hFF, 8'hFF, 8'h09, 8'h21};
    ready_viol = 0;
    do_start(32'd2);
    for (int i = 0; i < 8; i++) send_byte(b[i], int'($urandom_range(0, 3)));
    finish_check();
    wait_end("toggle");
    n_checks++;
    if (wr_addr.size() != 2) begin
      n_fail++;
      $display("FAIL toggle_count: writes=%0d, required 2", wr_addr.size());
    end else begin
      n_checks++;
      if (wr_data[0] !== 32'h2008_0020 || wr_data[1] !== 32'h2109_FFFF || wr_addr[1] !== 32'h0040_0004) begin
        n_fail++;
        $display("FAIL toggle_words: %h %h@%h, required 20080020 2109ffff@00400004", wr_data[0], wr_data[1], wr_addr[1]);
      end
    end
    n_checks++;
    if (ready_viol != 0) begin
      n_fail++;
      $display("FAIL toggle_ready_in_write: ready high in %0d write cycles, required 0", ready_viol);
    end
  endtask

  task automatic test_bad_count();
    do_start(32'd0);
    n_checks++;
    if (error_o !== 1'b1 || cpu_hold_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL count0_error: err=%0b hold=%0b busy=%0b done=%0b, required 1 1 0 0", error_o, cpu_hold_o, busy_o, done_o);
    end
    do_start(32'd33);
    n_checks++;
    if (error_o !== 1'b1 || cpu_hold_o !== 1'b1 || byte_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL count33_error: err=%0b hold=%0b ready=%0b, required 1 1 0", error_o, cpu_hold_o, byte_ready_o);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_addr.size() != 0) begin
      n_fail++;
      $display("FAIL badcount_writes: writes=%0d, required 0", wr_addr.size());
    end
    do_start(32'd1);
    n_checks++;
    if (error_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_from_error: err=%0b busy=%0b, required 0 1", error_o, busy_o);
    end
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
    finish_check();
    wait_end("count1");
    n_checks++;
    if (wr_addr.size() != 1 || wr_addr[0] !== BASE || wr_data[0] !== 32'h0 || done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL count1_load: writes=%0d done=%0b, required 1 write of 00000000@00400000 and done 1",
               wr_addr.size(), done_o);
    end
  endtask

  task automatic test_full_depth();
    logic [7:0]  bb;
    logic [31:0] exp_w;
    int          bad = 0;
    do_start(32'd32);
    for (int i = 0; i < 32; i++)
      for (int k = 0; k < 4; k++) begin
        bb = 8'(i * 4 + k) ^ 8'h5A;
        send_byte(bb, 0);
      end
    finish_check();
    wait_end("full");
    byte_valid_i = 1'b1;
    byte_i       = 8'hEE;
    repeat (10) @(negedge clk);
    byte_valid_i = 1'b0;
    n_checks++;
    if (wr_addr.size() != 32) begin
      n_fail++;
      $display("FAIL full_count: writes=%0d, required 32", wr_addr.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        exp_w = {8'(i*4+3) ^ 8'h5A, 8'(i*4+2) ^ 8'h5A, 8'(i*4+1) ^ 8'h5A, 8'(i*4) ^ 8'h5A};
        if (wr_data[i] !== exp_w || wr_addr[i] !== BASE + 32'(i * 4)) bad++;
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL full_words: %0d words wrong, required 0", bad);
      end
      n_checks++;
      if (wr_addr[31] !== 32'h0040_007C) begin
        n_fail++;
        $display("FAIL full_last_addr: %h, required 0040007c", wr_addr[31]);
      end
    end
    n_checks++;
    if (done_o !== 1'b1 || byte_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done: done=%0b ready=%0b, required 1 0", done_o, byte_ready_o);
    end
  endtask

  task automatic test_reset_in_write();
    do_start(32'd2);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 0);
    // The 8th byte was accepted on the last rising edge: the DUT is now in the WRITE of word 1.
    byte_valid_i = 1'b0;
    reset        = 1'b1;
    #1;
    n_checks++;
    if (mem_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstwr_strobe: mem_we_o=%0b during reset, required 0", mem_we_o);
    end
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({mem_we_o, byte_ready_o, cpu_hold_o, busy_o, done_o, error_o} !== 6'b0 ||
        mem_addr_o !== BASE || mem_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rstwr_state: flags=%b addr=%h data=%h, required 000000 00400000 00000000",
               {mem_we_o, byte_ready_o, cpu_hold_o, busy_o, done_o, error_o}, mem_addr_o, mem_data_o);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_addr.size() != 1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstwr_writes: writes=%0d busy=%0b, required 1 0", wr_addr.size(), busy_o);
    end
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int pass = 0; pass < 2; pass++) begin
      do_start(32'd1);
      send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
      send_byte(pass == 0 ? 8'hF6 : 8'hF7, 2);
      wait_end("checksum");
      n_checks++;
      if (wr_addr.size() != 1 || wr_data[0] !== 32'h0403_0201) begin
        n_fail++;
        $display("FAIL cks_write: writes=%0d, required 1 write of 04030201", wr_addr.size());
      end
      n_checks++;
      if (pass == 0 && (done_o !== 1'b1 || cpu_hold_o !== 1'b0)) begin
        n_fail++;
        $display("FAIL cks_good: done=%0b hold=%0b, required 1 0", done_o, cpu_hold_o);
      end else if (pass == 1 && (error_o !== 1'b1 || cpu_hold_o !== 1'b1 || done_o !== 1'b0)) begin
        n_fail++;
        $display("FAIL cks_bad: err=%0b hold=%0b done=%0b, required 1 1 0", error_o, cpu_hold_o, done_o);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_toggle();
    test_bad_count();
    test_full_depth();
    test_reset_in_write();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
